// File: rtl/pdm_decimator.sv
// PDM microphone front end: generates the mic clock, samples the 1-bit
// stream and decimates it with a 3rd-order CIC into signed 16-bit PCM.
module pdm_decimator #(
   parameter int CLK_DIV    = 8,
   parameter int DECIM_LOG2 = 6,
   parameter int CHANNEL    = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               M_DATA,
   output logic               M_CLK,
   output logic               M_LRSEL,
   output logic signed [15:0] pcm_out,
   output logic               pcm_ready,
   output logic               sat
);

   localparam int CW    = $clog2(CLK_DIV);
   localparam int HALF  = CLK_DIV / 2;
   localparam int W     = 3 * DECIM_LOG2 + 2;
   localparam int SHIFT = 3 * DECIM_LOG2 - 15;

   localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] CNT_HALF  = CW'(HALF);
   localparam logic [CW-1:0] CNT_PHASE = (CHANNEL == 0) ? CW'(HALF - 1) : CW'(CLK_DIV - 1);

   localparam logic signed [W-1:0] PLUS_ONE  = W'(1);
   localparam logic signed [W-1:0] MINUS_ONE = '1;
   localparam logic signed [W-1:0] PCM_MAX   = W'(32767);
   localparam logic signed [W-1:0] PCM_MIN   = -PCM_MAX - PLUS_ONE;

   // Divider state: 'running' distinguishes the first enabled cycle so that
   // the first M_CLK high phase is a full half period.
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic          running;
   logic          clear;
   logic          strobe;

   // Sampling path
   logic [1:0]           sync;
   logic signed [W-1:0]  x;

   // CIC datapath
   logic signed [W-1:0]   i1, i2, i3;
   logic signed [W-1:0]   z1, z2, z3;
   logic signed [W-1:0]   c1, c2, c3, y;
   logic [DECIM_LOG2-1:0] dec_cnt;
   logic                  dec_t;
   logic                  stb_d1, stb_d2;
   logic                  dec_d1, dec_d2, dec_d3;
   logic [1:0]            warm;
   logic signed [15:0]    pcm_c;
   logic                  sat_c;

   assign M_LRSEL = (CHANNEL != 0);
   assign clear   = rst || !en;
   assign strobe  = running && !clear && (cnt == CNT_PHASE);
   assign dec_t   = strobe && (dec_cnt == '1);
   assign x       = sync[1] ? PLUS_ONE : MINUS_ONE;

   // Next divider count; held at 0 until the divider is running.
   // NOTE: every signal driven in always_comb gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      cnt_next = '0;
      if (running && cnt != CNT_MAX) cnt_next = cnt + CW'(1);
   end

   // Clock divider; M_CLK is registered from the next count so it is glitch-free.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (clear) begin
         cnt     <= '0;
         running <= 1'b0;
         M_CLK   <= 1'b0;
      end else begin
         cnt     <= cnt_next;
         running <= 1'b1;
         M_CLK   <= (cnt_next < CNT_HALF);
      end
   end

   // Two-flop synchronizer for the asynchronous PDM data.
   always_ff @(posedge clk) begin
      if (rst) sync <= '0;
      else     sync <= {sync[0], M_DATA};
   end

   // Pipelined integrators and decimation bookkeeping; one stage per cycle.
   always_ff @(posedge clk) begin
      if (clear) begin
         i1      <= '0;
         i2      <= '0;
         i3      <= '0;
         stb_d1  <= 1'b0;
         stb_d2  <= 1'b0;
         dec_cnt <= '0;
         dec_d1  <= 1'b0;
         dec_d2  <= 1'b0;
         dec_d3  <= 1'b0;
      end else begin
         if (strobe) i1 <= i1 + x;
         if (stb_d1) i2 <= i2 + i1;
         if (stb_d2) i3 <= i3 + i2;
         stb_d1 <= strobe;
         stb_d2 <= stb_d1;
         if (strobe) dec_cnt <= dec_cnt + DECIM_LOG2'(1);
         dec_d1 <= dec_t;
         dec_d2 <= dec_d1;
         dec_d3 <= dec_d2;
      end
   end

   // Comb chain at the decimated rate; differences wrap modulo 2^W.
   assign c1 = i3 - z1;
   assign c2 = c1 - z2;
   assign c3 = c2 - z3;
   assign y  = c3 >>> SHIFT;

   // Comb delay registers, loaded once per decimated sample.
   always_ff @(posedge clk) begin
      if (clear) begin
         z1 <= '0;
         z2 <= '0;
         z3 <= '0;
      end else if (dec_d3) begin
         z1 <= i3;
         z2 <= c1;
         z3 <= c2;
      end
   end

   // Clamp the scaled comb output to the 16-bit PCM range.
   always_comb begin
      pcm_c = y[15:0];
      sat_c = 1'b0;
      if (y > PCM_MAX) begin
         pcm_c = 16'sh7FFF;
         sat_c = 1'b1;
      end else if (y < PCM_MIN) begin
         pcm_c = -16'sh8000;
         sat_c = 1'b1;
      end
   end

   // Output register; the first three decimated samples only advance warm-up.
   always_ff @(posedge clk) begin
      if (rst) begin
         pcm_out   <= '0;
         pcm_ready <= 1'b0;
         sat       <= 1'b0;
         warm      <= '0;
      end else begin
         pcm_ready <= 1'b0;
         sat       <= 1'b0;
         if (!en) begin
            warm <= '0;
         end else if (dec_d3) begin
            if (warm == 2'd3) begin
               pcm_out   <= pcm_c;
               pcm_ready <= 1'b1;
               sat       <= sat_c;
            end else begin
               warm <= warm + 2'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pdm_decimator.sv
// Bench for pdm_decimator: acts as the microphone on its own schedule,
// predicts every PCM sample from a direct-form CIC kernel and checks them.
module tb_pdm_decimator;

   localparam int CLK_DIV    = 8;
   localparam int DECIM_LOG2 = 6;
   localparam int CHANNEL    = 0;
   localparam int R          = 1 << DECIM_LOG2;
   localparam int HLEN       = 3 * R - 2;
   localparam int SHIFT      = 3 * DECIM_LOG2 - 15;
   localparam int LATENCY    = (CLK_DIV / 2 - 1) + 4;

   typedef enum int {ONES, ZEROS, TOGGLE, QUARTER, RANDOM} mode_t;
   typedef struct {
      int val;
      int sat;
      int cyc;
   } exp_t;

   logic               clk    = 1'b0;
   logic               rst    = 1'b1;
   logic               en     = 1'b1;
   logic               M_DATA = 1'b0;
   logic               M_CLK;
   logic               M_LRSEL;
   logic signed [15:0] pcm_out;
   logic               pcm_ready;
   logic               sat;

   int   n_tests   = 0;
   int   n_fail    = 0;
   int   cyc       = 0;
   int   run_start = -1;
   int   xs[$];
   exp_t sb[$];
   int   h[HLEN];
   int   last_pcm  = 0;
   int   last_sat  = 0;
   exp_t mon_e;
   int   exp_mclk;

   pdm_decimator #(
      .CLK_DIV   (CLK_DIV),
      .DECIM_LOG2(DECIM_LOG2),
      .CHANNEL   (CHANNEL)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .M_DATA   (M_DATA),
      .M_CLK    (M_CLK),
      .M_LRSEL  (M_LRSEL),
      .pcm_out  (pcm_out),
      .pcm_ready(pcm_ready),
      .sat      (sat)
   );

   always #20 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // CIC impulse response: three boxcars of length R convolved together.
   task automatic build_kernel();
      int h2[2*R-1];
      for (int i = 0; i < 2*R-1; i++) h2[i] = 0;
      for (int i = 0; i < HLEN; i++) h[i] = 0;
      for (int i = 0; i < R; i++)
         for (int j = 0; j < R; j++) h2[i+j] += 1;
      for (int i = 0; i < 2*R-1; i++)
         for (int j = 0; j < R; j++) h[i+j] += h2[i];
   endtask

   // Reference: each decimated output is the kernel applied to the input history.
   task automatic model_push(input bit b);
      int   n;
      int   acc;
      int   y;
      exp_t e;
      xs.push_back(b ? 1 : -1);
      n = xs.size();
      if (n % R == 0 && n / R >= 4) begin
         acc = 0;
         for (int j = 0; j < HLEN; j++)
            if (n - 1 - j >= 0) acc += h[j] * xs[n-1-j];
         y     = acc >>> SHIFT;
         e.sat = 0;
         if (y > 32767) begin
            y = 32767;  e.sat = 1;
         end else if (y < -32768) begin
            y = -32768; e.sat = 1;
         end
         e.val = y;
         e.cyc = run_start + CLK_DIV * (n - 1) + LATENCY;
         sb.push_back(e);
      end
   endtask

   function automatic bit next_bit(input mode_t mode);
      int k;
      k = xs.size();
      case (mode)
         ONES:    return 1'b1;
         ZEROS:   return 1'b0;
         TOGGLE:  return (k % 2) == 0;
         QUARTER: return (k % 4) == 0;
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   // One clock of microphone behaviour: new bit at the start of each high phase.
   task automatic tick(input mode_t mode);
      bit b;
      @(negedge clk);
      if (run_start >= 0 && cyc >= run_start && ((cyc - run_start) % CLK_DIV) == 0) begin
         b      = next_bit(mode);
         M_DATA = b;
         model_push(b);
      end
   endtask

   task automatic ctrl(input logic r, input logic e);
      rst = r;
      en  = e;
      if (!r && e) begin
         if (run_start < 0) run_start = cyc + 1;
      end else begin
         run_start = -1;
         xs.delete();
         sb.delete();
      end
   endtask

   task automatic run_cycles(input mode_t mode, input int n);
      for (int i = 0; i < n; i++) tick(mode);
   endtask

   task automatic run_until(input mode_t mode, input int target);
      while (xs.size() < target) tick(mode);
   endtask

   // Monitor: clock shape, output holding and scoreboard comparison.
   always @(posedge clk) begin
      #1;
      exp_mclk = (run_start >= 0 && cyc >= run_start &&
                  ((cyc - run_start) % CLK_DIV) < CLK_DIV / 2) ? 1 : 0;
      check("m_clk", M_CLK, exp_mclk);
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         check("pcm_missing_at_cycle", cyc, sb[0].cyc);
         void'(sb.pop_front());
      end
      if (rst) begin
         last_pcm = 0;
         last_sat = 0;
      end
      if (pcm_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_pcm_ready", pcm_ready, 0);
         end else begin
            mon_e = sb.pop_front();
            check("pcm_cycle", cyc, mon_e.cyc);
            check("pcm_out", $signed(pcm_out), mon_e.val);
            check("sat", sat, mon_e.sat);
            last_pcm = $signed(pcm_out);
            last_sat = sat;
         end
      end else begin
         check("pcm_hold", $signed(pcm_out), last_pcm);
      end
   end

   initial begin
      build_kernel();

      // Reset state with enable already high.
      repeat (5) begin
         @(negedge clk);
         check("rst_pcm_out", $signed(pcm_out), 0);
         check("rst_pcm_ready", pcm_ready, 0);
         check("rst_sat", sat, 0);
         check("m_lrsel", M_LRSEL, CHANNEL);
      end
      ctrl(1'b0, 1'b1);

      // Positive full scale clamps.
      run_until(ONES, 6 * R);
      run_cycles(ZEROS, 8);
      check("pos_full_pcm", last_pcm, 32767);
      check("pos_full_sat", last_sat, 1);

      // Negative full scale fits exactly.
      run_until(ZEROS, 11 * R);
      run_cycles(TOGGLE, 8);
      check("neg_full_pcm", last_pcm, -32768);
      check("neg_full_sat", last_sat, 0);

      // Idle tone averages to zero.
      run_until(TOGGLE, 16 * R);
      run_cycles(QUARTER, 8);
      check("idle_pcm", last_pcm, 0);
      check("idle_sat", last_sat, 0);

      // Quarter density gives half negative scale.
      run_until(QUARTER, 21 * R);
      run_cycles(RANDOM, 8);
      check("half_pcm", last_pcm, -16384);
      check("half_sat", last_sat, 0);

      // Random density against the reference.
      run_until(RANDOM, 25 * R);

      // Mid-frame reset pulse, then enable dropped for 100 cycles.
      run_cycles(RANDOM, $urandom_range(20, 400));
      ctrl(1'b1, 1'b1);
      tick(RANDOM);
      ctrl(1'b0, 1'b1);
      run_cycles(RANDOM, 300);
      ctrl(1'b0, 1'b0);
      run_cycles(RANDOM, 100);
      check("en_low_pcm_ready", pcm_ready, 0);
      check("m_lrsel_end", M_LRSEL, CHANNEL);
      ctrl(1'b0, 1'b1);

      // Warm-up restarts; first output arrives at the 4th decimation.
      run_until(QUARTER, 6 * R);
      run_cycles(QUARTER, 16);
      check("restart_half_pcm", last_pcm, -16384);
      check("scoreboard_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
